// File: rtl/ahb_master_arbiter_if.sv
// Requester-side and AHB-master-side transaction signals of ahb_master_arbiter.
// The master modport is the arbiter's view. The slave modport is the environment's view.
interface ahb_master_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_rd0_wr1;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_req_rd_valid;
  logic [DATA_WIDTH-1:0]         o_req_rd_data;

  logic                          o_m_valid;
  logic                          o_m_rd0_wr1;
  logic [ADDR_WIDTH-1:0]         o_m_addr;
  logic [DATA_WIDTH-1:0]         o_m_wr_data;
  logic                          i_m_ready;
  logic                          i_m_rd_valid;
  logic [DATA_WIDTH-1:0]         i_m_rd_data;

  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_err_unexp_rd;

  modport master (
    input  i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
    output o_req_ready, o_req_rd_valid, o_req_rd_data,
    output o_m_valid, o_m_rd0_wr1, o_m_addr, o_m_wr_data,
    input  i_m_ready, i_m_rd_valid, i_m_rd_data,
    output o_grant, o_err_unexp_rd
  );

  modport slave (
    output i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
    input  o_req_ready, o_req_rd_valid, o_req_rd_data,
    input  o_m_valid, o_m_rd0_wr1, o_m_addr, o_m_wr_data,
    output i_m_ready, i_m_rd_valid, i_m_rd_data,
    input  o_grant, o_err_unexp_rd
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Arbitrates NUM_REQ requesters onto one AHB master port and routes read data back through a tag FIFO.
// The default build uses round-robin arbitration. Defining AHB_ARB_FIXED_PRIO_EN selects fixed priority, where the lowest index wins.
module ahb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  ahb_master_arbiter_if.master  bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int TAG_AW = $clog2(TAG_DEPTH);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

  arb_state_t          state_q, state_d;
  idx_t                rr_ptr_q, rr_ptr_d;
  idx_t                hold_idx_q, hold_idx_d;

  idx_t                tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0]   tag_wr_ptr_q, tag_rd_ptr_q;
  logic [TAG_AW:0]     tag_cnt_q;
  logic                err_unexp_rd_q;

  logic                tag_empty, tag_full, tag_push, tag_pop;
  idx_t                tag_head;
  logic [NUM_REQ-1:0]  elig;
  idx_t                search_start, cand;
  logic                sel_vld;
  idx_t                sel_idx;
  logic                gnt_vld;
  idx_t                gnt_idx;
  logic                accept;

  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == (TAG_AW+1)'(TAG_DEPTH));
  assign tag_pop   = bus.i_m_rd_valid && !tag_empty && i_rstn_ahb;
  assign tag_head  = tag_mem[tag_rd_ptr_q];

  // A pop in the same cycle frees a slot, so a read stays eligible on a full FIFO when data is returning.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = bus.i_req_valid[k] && (bus.i_req_rd0_wr1[k] || !tag_full || tag_pop);
    end
  end

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  assign search_start = rr_ptr_q;
`endif

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = idx_t'((int'(search_start) + i) % NUM_REQ);
      if (!sel_vld && elig[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_idx_d = hold_idx_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    accept     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        gnt_vld = sel_vld;
        gnt_idx = sel_idx;
        if (sel_vld && !bus.i_m_ready) begin
          state_d    = ARB_HOLD;
          hold_idx_d = sel_idx;
        end
      end
      ARB_HOLD: begin
        // The held requester is forwarded alone. If it withdraws, the grant is dropped without an accept.
        gnt_idx = hold_idx_q;
        gnt_vld = bus.i_req_valid[hold_idx_q];
        if (!gnt_vld || bus.i_m_ready) begin
          state_d    = ARB_IDLE;
          hold_idx_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    gnt_vld = gnt_vld && i_rstn_ahb;
    accept  = gnt_vld && bus.i_m_ready;
`ifndef AHB_ARB_FIXED_PRIO_EN
    if (accept) begin
      rr_ptr_d = (gnt_idx == idx_t'(NUM_REQ-1)) ? '0 : idx_t'(gnt_idx + 1'b1);
    end
`endif
  end

  always_comb begin
    bus.o_m_valid   = gnt_vld;
    bus.o_m_rd0_wr1 = 1'b0;
    bus.o_m_addr    = '0;
    bus.o_m_wr_data = '0;
    bus.o_grant     = '0;
    bus.o_req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_vld && gnt_idx == idx_t'(k)) begin
        bus.o_m_rd0_wr1    = bus.i_req_rd0_wr1[k];
        bus.o_m_addr       = bus.i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        bus.o_m_wr_data    = bus.i_req_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        bus.o_grant[k]     = 1'b1;
        bus.o_req_ready[k] = bus.i_m_ready;
      end
    end
  end

  assign tag_push = accept && !bus.o_m_rd0_wr1;

  always_comb begin
    bus.o_req_rd_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.o_req_rd_valid[k] = tag_pop && (tag_head == idx_t'(k));
    end
    bus.o_req_rd_data = (bus.i_m_rd_valid && i_rstn_ahb) ? bus.i_m_rd_data : '0;
  end

  assign bus.o_err_unexp_rd = err_unexp_rd_q;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q        <= ARB_IDLE;
      rr_ptr_q       <= '0;
      hold_idx_q     <= '0;
      tag_wr_ptr_q   <= '0;
      tag_rd_ptr_q   <= '0;
      tag_cnt_q      <= '0;
      err_unexp_rd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_idx_q <= hold_idx_d;
      if (tag_push) tag_wr_ptr_q <= tag_wr_ptr_q + 1'b1;
      if (tag_pop)  tag_rd_ptr_q <= tag_rd_ptr_q + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
      if (bus.i_m_rd_valid && tag_empty) err_unexp_rd_q <= 1'b1;
    end
  end

  // Tag storage carries no reset. Entries are only read below the count.
  always_ff @(posedge i_clk_ahb) begin
    if (tag_push) tag_mem[tag_wr_ptr_q] <= gnt_idx;
  end
endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning number of requesters (legal 2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-004 SHALL have parameter TAG_DEPTH, default 4, meaning read-tag FIFO depth (power of 2, >=2).
REQ-005 SHALL have port i_clk_ahb, input, 1, clock; reset i_rstn_ahb, asynchronous, active-low; clock i_clk_ahb.
REQ-006 SHALL have port i_rstn_ahb, input, 1, async active-low reset.
REQ-007 SHALL have port i_req_valid, input, NUM_REQ, per-requester transaction request.
REQ-008 SHALL have port i_req_rd0_wr1, input, NUM_REQ, per-requester direction (0 read, 1 write).
REQ-009 SHALL have port i_req_addr, input, NUM_REQ*ADDR_WIDTH, packed addresses, requester k at slice k.
REQ-010 SHALL have port i_req_wr_data, input, NUM_REQ*DATA_WIDTH, packed write data.
REQ-011 SHALL have port o_req_ready, output, NUM_REQ, one-hot acceptance to the granted requester.
REQ-012 SHALL have port o_req_rd_valid, output, NUM_REQ, one-hot read-data strobe.
REQ-013 SHALL have port o_req_rd_data, output, DATA_WIDTH, shared read data.
REQ-014 SHALL have ports o_m_valid/o_m_rd0_wr1 (1), o_m_addr (ADDR_WIDTH), o_m_wr_data (DATA_WIDTH), outputs to the AHB master transaction port.
REQ-015 SHALL have ports i_m_ready, i_m_rd_valid (1), i_m_rd_data (DATA_WIDTH), inputs from the AHB master.
REQ-016 SHALL have port o_grant, output, NUM_REQ, current one-hot grant (all zero when none).
REQ-017 SHALL have port o_err_unexp_rd, output, 1, sticky flag: read data with no tag outstanding.

Function
REQ-018 SHALL implement FSM ARB_IDLE / ARB_HOLD; accept = o_m_valid && i_m_ready.
REQ-019 ARB_IDLE: eligible requester chosen combinationally, same cycle (zero-latency) drive o_m_* from its slices, o_grant and o_req_ready[k]=i_m_ready.
REQ-020 ARB_IDLE, grant issued, no accept -> register grant, go ARB_HOLD; accept -> stay ARB_IDLE.
REQ-021 ARB_HOLD: held requester forwarded regardless of other requests; accept -> ARB_IDLE.
REQ-022 ARB_HOLD, held requester drops i_req_valid -> o_m_valid=0 that cycle, return ARB_IDLE, no accept, no tag push.
REQ-023 Round-robin: pointer resets to 0; search starts at pointer; on accept pointer = granted index+1 mod NUM_REQ.
REQ-024 Read tag FIFO: accepted read pushes granted index; i_m_rd_valid pops head k, drives o_req_rd_valid[k]=1, o_req_rd_data=i_m_rd_data same cycle.
REQ-025 FIFO full -> read requests ineligible (writes still eligible); HOLD of a read with FIFO full SHALL NOT occur since FIFO only fills on accept.
REQ-026 Simultaneous push and pop: both performed, count unchanged; pop on full frees space for the same-cycle push.
REQ-027 i_m_rd_valid with FIFO empty: no o_req_rd_valid, set o_err_unexp_rd (cleared only by reset); same-cycle push still performed.
REQ-028 No eligible request -> o_m_valid=0, o_grant=0, o_req_ready=0, o_m_addr/o_m_wr_data/o_m_rd0_wr1=0.
REQ-029 o_req_rd_data SHALL be 0 when i_m_rd_valid=0.

Reset
REQ-030 On reset: state ARB_IDLE, pointer 0, FIFO empty, held grant 0, o_err_unexp_rd 0; all outputs 0 while asserted.
REQ-031 Reset mid-HOLD or with tags outstanding SHALL discard them; subsequent read data -> REQ-027.

Configuration
REQ-032 Macro AHB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer unused (held at 0).
REQ-033 Macro AHB_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-023; HOLD/tag behaviour identical in both builds.

Verification
REQ-034 Both requesters valid, i_m_ready=1, 4 cycles, round-robin build -> grants 0,1,0,1; fixed-prio build -> 0,0,0,0.
REQ-035 Req1 write addr 0x10 data 0xA5, i_m_ready=0 two cycles, req0 asserts meanwhile -> o_grant stays 0b10 until accept, then req0 granted.
REQ-036 Req0 read 0x20, req1 read 0x24 accepted; i_m_rd_valid with 0x1111 then 0x2222 -> o_req_rd_valid 0b01 data 0x1111, then 0b10 data 0x2222.
REQ-037 Four reads accepted (TAG_DEPTH=4), no returns; req0 read + req1 write pending -> only write issued; one return same cycle as read accept -> count stays 4.
REQ-038 i_m_rd_valid=1 after reset, no tags -> o_req_rd_valid=0, o_err_unexp_rd=1 sticky until reset.
REQ-039 Reset asserted in ARB_HOLD -> next cycle all outputs 0, o_grant=0, FIFO empty.
